// File: rtl/dram_arbiter.sv
// Round-robin arbiter and access sequencer sharing one DRAM port between NUM_CORES cores.
// Latency: write gnt at T+1, done at T+2; read gnt at T+1, done at T+2+READ_LAT (T = IDLE sample cycle).
// Backpressure: level req held until done; one access in flight, bundles captured only in IDLE.
// Optional: define DRAM_ARB_FIXED_PRIO_EN for fixed priority (lowest asserted index wins).
module dram_arbiter #(
  parameter int NUM_CORES = 2,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int READ_LAT  = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CORES-1:0]           req,
  input  logic [NUM_CORES-1:0]           req_we,
  input  logic [NUM_CORES*ADDR_W-1:0]    req_addr,
  input  logic [NUM_CORES*DATA_W-1:0]    req_wdata,
  output logic [NUM_CORES-1:0]           gnt,
  output logic [NUM_CORES-1:0]           done,
  output logic [DATA_W-1:0]              rdata,
  output logic                           mem_en,
  output logic                           mem_we,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic [DATA_W-1:0]              mem_rdata
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  // Counter only ever holds READ_LAT-1 down to 0.
  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [IDX_W-1:0]      r_sel;
  logic [CNT_W-1:0]      r_cnt;
  logic [NUM_CORES-1:0]  r_gnt;
  logic [NUM_CORES-1:0]  r_done;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_mem_en;
  logic                  r_mem_we;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [DATA_W-1:0]     r_mem_wdata;
`ifndef DRAM_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]      r_last;
`endif

  logic [IDX_W-1:0]      w_win;
  logic [IDX_W-1:0]      w_cand;
  logic                  w_any;

  // Winner search: from the slot after the last winner with wrap (or from index 0 in fixed mode).
  always_comb begin
    w_win  = '0;
    w_any  = 1'b0;
    w_cand = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
`ifdef DRAM_ARB_FIXED_PRIO_EN
      w_cand = IDX_W'(k);
`else
      w_cand = IDX_W'((int'(r_last) + 1 + k) % NUM_CORES);
`endif
      if (!w_any && req[w_cand]) begin
        w_any = 1'b1;
        w_win = w_cand;
      end
    end
  end

  // Access sequencer: arbitrate in IDLE, issue one DRAM cycle, wait out read latency, pulse done.
  // The mem_we/mem_addr/mem_wdata registers double as the captured request bundle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sel       <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_rdata     <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
`ifndef DRAM_ARB_FIXED_PRIO_EN
      r_last      <= IDX_W'(NUM_CORES - 1);
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_sel       <= w_win;
            r_gnt       <= NUM_CORES'(1) << w_win;
            r_mem_en    <= 1'b1;
            r_mem_we    <= req_we[w_win];
            r_mem_addr  <= req_addr[int'(w_win)*ADDR_W +: ADDR_W];
            r_mem_wdata <= req_wdata[int'(w_win)*DATA_W +: DATA_W];
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_gnt    <= '0;
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
          if (r_mem_we) begin
            r_done  <= NUM_CORES'(1) << r_sel;
            r_state <= S_DONE;
          end else begin
            r_cnt   <= CNT_W'(READ_LAT - 1);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_rdata <= mem_rdata;
            r_done  <= NUM_CORES'(1) << r_sel;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          r_done  <= '0;
`ifndef DRAM_ARB_FIXED_PRIO_EN
          r_last  <= r_sel;
`endif
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign done      = r_done;
  assign rdata     = r_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dram_arbiter.sv
// Testbench for dram_arbiter: 3 cores, READ_LAT=3, DRAM stand-in with a true read pipeline.
// Directed steps followed by randomized traffic checked against a transaction-level model.
module tb_dram_arbiter;
  localparam int NC = 3;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int RL = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NC-1:0]     req;
  logic [NC-1:0]     req_we;
  logic [NC*AW-1:0]  req_addr;
  logic [NC*DW-1:0]  req_wdata;
  logic [NC-1:0]     gnt;
  logic [NC-1:0]     done;
  logic [DW-1:0]     rdata;
  logic              mem_en;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;

  always #5 clk = ~clk;

  dram_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL)) u_dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] init_word(input int a);
    return (DW'(a) * 32'h0001_0203) ^ 32'h5A00_0000;
  endfunction

  // DRAM stand-in: write on the strobe edge, read data appears RL cycles after the issue cycle.
  logic          dram_init;
  logic [DW-1:0] dram  [0:(1<<AW)-1];
  logic [DW-1:0] rpipe [0:RL-1];
  always @(posedge clk) begin
    if (dram_init) begin
      for (int a = 0; a < 16; a++) dram[a] <= init_word(a);
    end else if (mem_en && mem_we) begin
      dram[mem_addr] <= mem_wdata;
    end
    rpipe[0] <= (mem_en && !mem_we) ? dram[mem_addr] : 32'hDEAD_BEEF;
    for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata = rpipe[RL-1];

  // Reference model state
  int            n_checks;
  int            n_err;
  int            last_m;
  logic [DW-1:0] exp_rdata;
  logic [DW-1:0] ref_mem [0:15];
  logic          b_we    [NC];
  logic [AW-1:0] b_addr  [NC];
  logic [DW-1:0] b_wdata [NC];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_core(input int c);
    req_we[c]               = b_we[c];
    req_addr[c*AW +: AW]    = b_addr[c];
    req_wdata[c*DW +: DW]   = b_wdata[c];
  endtask

  task automatic set_core(input int c, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    b_we[c] = we; b_addr[c] = a; b_wdata[c] = d;
    drive_core(c);
  endtask

  task automatic rand_core(input int c);
    b_we[c]    = 1'($urandom % 2);
    b_addr[c]  = AW'($urandom_range(0, 15));
    b_wdata[c] = $urandom;
    drive_core(c);
  endtask

  // Arbitration rule from the winner's point of view: first requester after the last winner.
  function automatic int model_winner(input logic [NC-1:0] m);
`ifdef DRAM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NC; i++) if (m[i]) return i;
`else
    for (int k = 1; k <= NC; k++) if (m[(last_m + k) % NC]) return (last_m + k) % NC;
`endif
    return -1;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_en"}, mem_en, 0);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_rdata"}, rdata, 0);
  endtask

  // One complete access, entered in the IDLE cycle that samples the request; leaves in the next IDLE.
  task automatic access(input int w, input bit keep, input bit chg);
    logic [NC-1:0] oh;
    oh = NC'(1) << w;
    tick();
    chk("issue_gnt", gnt, oh);
    chk("issue_en", mem_en, 1);
    chk("issue_we", mem_we, b_we[w]);
    chk("issue_addr", mem_addr, b_addr[w]);
    chk("issue_wdata", mem_wdata, b_wdata[w]);
    chk("issue_done", done, 0);
    if (b_we[w]) begin
      ref_mem[b_addr[w][3:0]] = b_wdata[w];
    end else begin
      for (int i = 0; i < RL; i++) begin
        tick();
        if (chg && i == 0) req_addr[w*AW +: AW] = ~b_addr[w];
        chk("wait_en", mem_en, 0);
        chk("wait_gnt", gnt, 0);
        chk("wait_done", done, 0);
        chk("wait_addr", mem_addr, b_addr[w]);
      end
      exp_rdata = ref_mem[b_addr[w][3:0]];
    end
    tick();
    chk("done_pulse", done, oh);
    chk("done_rdata", rdata, exp_rdata);
    chk("done_gnt", gnt, 0);
    chk("done_en", mem_en, 0);
    if (chg) drive_core(w);
    if (!keep) req[w] = 1'b0;
    last_m = w;
    tick();
    chk("idle_gnt", gnt, 0);
    chk("idle_done", done, 0);
    chk("idle_en", mem_en, 0);
  endtask

  initial begin
    int w;
    int seq [4];
    n_checks = 0;
    n_err = 0;
    rst = 1'b1;
    dram_init = 1'b1;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    for (int a = 0; a < 16; a++) ref_mem[a] = init_word(a);
    for (int c = 0; c < NC; c++) begin b_we[c] = 1'b0; b_addr[c] = '0; b_wdata[c] = '0; end
    last_m = NC - 1;
    exp_rdata = '0;
    repeat (3) tick();
    dram_init = 1'b0;
    chk_all_zero("reset");
    rst = 1'b0;

    // Core0 writes 0x0C to 0x001, then core1 reads it back.
    set_core(0, 1'b1, 12'h001, 32'h0000_000C);
    req = 3'b001;
    access(0, 1'b0, 1'b0);
    set_core(1, 1'b0, 12'h001, 32'h0);
    req = 3'b010;
    access(1, 1'b0, 1'b0);
    chk("rd_back_0c", rdata, 32'h0000_000C);

    // Sole requester is granted even though it was the last winner.
    set_core(1, 1'b0, 12'h003, 32'h0);
    req = 3'b010;
    access(1, 1'b0, 1'b0);

    // Address change during WAIT must not affect the access in flight.
    set_core(0, 1'b0, 12'h001, 32'h0);
    req = 3'b001;
    access(0, 1'b0, 1'b1);

    // Reset in the middle of a read's WAIT phase aborts it.
    set_core(1, 1'b0, 12'h005, 32'h0);
    req = 3'b010;
    tick();
    chk("abort_issue_gnt", gnt, 3'b010);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk_all_zero("midrst");
    rst = 1'b0;
    req = '0;
    last_m = NC - 1;
    exp_rdata = '0;
    tick();
    chk("postrst_done", done, 0);
    chk("postrst_en", mem_en, 0);

    // Two persistent requesters straight after reset.
    set_core(0, 1'b1, 12'h002, 32'h1111_0000);
    set_core(1, 1'b1, 12'h003, 32'h2222_0000);
    req = 3'b011;
`ifdef DRAM_ARB_FIXED_PRIO_EN
    seq = '{0, 0, 0, 0};
`else
    seq = '{0, 1, 0, 1};
`endif
    for (int i = 0; i < 4; i++) access(seq[i], 1'b1, 1'b0);
    req = '0;

    // Randomized traffic against the model.
    for (int it = 0; it < 60; it++) begin
      for (int c = 0; c < NC; c++) begin
        if (!req[c] && ($urandom % 2 == 1)) begin
          rand_core(c);
          req[c] = 1'b1;
        end
      end
      if (req == '0) begin
        int c;
        c = $urandom_range(0, NC - 1);
        rand_core(c);
        req[c] = 1'b1;
      end
      w = model_winner(req);
      access(w, ($urandom % 4) == 0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Round-robin arbiter and access sequencer that shares one data-memory (DRAM) port between NUM_CORES processor cores.
- Accepts per-core request bundles (address, write enable, write data), grants one core at a time and drives the shared DRAM port.
- Sequences the read latency, then returns read data and a one-cycle done pulse to the granted core.
- Sits between the cores' AR/DR/DRAM_we outputs and the single DRAM instance in the multi-core processor top.

Parameters:
- NUM_CORES, 2, number of requesting cores (2..4)
- ADDR_W, 12, DRAM address width (matches the AR width)
- DATA_W, 32, data width (matches the DR width)
- READ_LAT, 1, DRAM read latency in cycles after the issue cycle (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- req  in  NUM_CORES  per-core access request, level
- req_we  in  NUM_CORES  per-core write enable (1=write, 0=read)
- req_addr  in  NUM_CORES*ADDR_W  per-core address; core i occupies bits [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_CORES*DATA_W  per-core write data; same packing scheme
- gnt  out  NUM_CORES  one-hot grant pulse, asserted in the ISSUE cycle
- done  out  NUM_CORES  one-hot completion pulse, asserted in the DONE cycle
- rdata  out  DATA_W  read data, valid while done is high for a read
- mem_en  out  1  DRAM access strobe
- mem_we  out  1  DRAM write enable (the DRAM_we equivalent)
- mem_addr  out  ADDR_W  DRAM address
- mem_wdata  out  DATA_W  DRAM write data
- mem_rdata  in  DATA_W  DRAM read data

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE; gnt, done, mem_en, mem_we all 0; mem_addr, mem_wdata, rdata all 0.
  - Round-robin pointer last=NUM_CORES-1, so core 0 has first priority.
- Reset mid-operation aborts the access: no done pulse is issued and no further DRAM cycles occur.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If req is nonzero, select the winner w = first set bit searching from (last+1) mod NUM_CORES upward, with wrap-around.
  - Capture w, req_we[w], req_addr[w] and req_wdata[w]; go to ISSUE.
  - Otherwise remain in IDLE.
- ISSUE (1 cycle):
  - gnt[w]=1, mem_en=1; mem_we, mem_addr and mem_wdata come from the captured values.
  - Write: next state DONE. Read: next state WAIT, with cnt=READ_LAT-1.
- WAIT (READ_LAT cycles):
  - mem_en=0, mem_we=0.
  - When cnt==0, capture mem_rdata into rdata and go to DONE; otherwise decrement cnt.
- DONE (1 cycle):
  - done[w]=1; rdata is held (it keeps its last value after a write).
  - last<=w; next state IDLE.
- Latency, for a request sampled in IDLE cycle T:
  - Write: gnt at T+1, done at T+2.
  - Read: gnt at T+1, done at T+2+READ_LAT.
- Handshake:
  - A core holds req, req_we, req_addr and req_wdata stable from assertion until it samples done=1.
  - It clears req at that same edge; a registered requester therefore has req low in the following IDLE cycle.
  - Changes to req bundles during ISSUE, WAIT or DONE are ignored because values are captured in IDLE.
- Boundaries:
  - Only one access is in flight at a time.
  - A single requester is always granted regardless of pointer position.
  - Simultaneous requests are resolved round-robin, so two persistent requesters alternate.
  - Back-to-back accesses have one IDLE arbitration cycle between DONE and the next ISSUE.
  - A req bit held high after done is treated as a new request.

Optional Feature:
- Macro: DRAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, where the lowest asserted index always wins; last is not updated and not used.
- Undefined: round-robin as specified above.

Test Plan:
- Reset, then core0 writes 0x0000000C to addr 0x001 -> gnt=01 at T+1; mem_en=1, mem_we=1, mem_addr=0x001, mem_wdata=0x0C; done=01 at T+2.
- Core1 reads addr 0x001 with READ_LAT=1 and DRAM returning 0x0C -> gnt=10 at T+1, mem_we=0; done=10 at T+3 with rdata=0x0000000C.
- Both cores hold req continuously after reset -> grants occur in the order 01,10,01,10 (with DRAM_ARB_FIXED_PRIO_EN: 01,01,01).
- Only core1 requests, with last=1 -> core1 is still granted at T+1.
- With READ_LAT=3, assert rst during WAIT -> next cycle state=IDLE, all outputs 0, no done pulse, core0 wins the next arbitration.
- Core0 changes req_addr during WAIT -> mem_addr and the completed access still use the address captured in IDLE.
